// File: rtl/stdp_weight_update_pkg.sv
// Shared constants, types and helpers for the STDP synapse weight-update block.
// Optional feature macro: STDP_DEPRESS_EN (enables depression on pre spikes).
package stdp_weight_update_pkg;

    localparam int                CNT_W      = 5;
    localparam logic [CNT_W-1:0]  CNT_SAT    = 5'd31;
    localparam int                WEIGHT_W   = 8;

    localparam int                DEF_W_INIT = 64;
    localparam int                DEF_A_MAX  = 16;
    localparam int                DEF_WINDOW = 15;

    typedef enum logic [1:0] {
        UPD_NONE,
        UPD_LTP,
        UPD_LTD
    } upd_kind_t;

    // Age of the partner spike as seen on the edge now being taken: the
    // stored count plus the cycle that is ending, held at saturation.
    function automatic logic [CNT_W-1:0] spike_age(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_SAT) ? CNT_SAT : cnt + 1'b1;
    endfunction

    // A spike age qualifies for learning when it lies in 1..window.
    function automatic logic in_window(input logic [CNT_W-1:0] c, input int window);
        return (c != '0) && (int'({{(32-CNT_W){1'b0}}, c}) <= window);
    endfunction

    // Step size halves for every four cycles of age; A_MAX fits in the weight width.
    function automatic logic [WEIGHT_W:0] stdp_delta(input int a_max, input logic [CNT_W-1:0] c);
        logic [WEIGHT_W:0] base;
        base = {1'b0, a_max[WEIGHT_W-1:0]};
        return base >> c[CNT_W-1:2];
    endfunction

endpackage

// File: rtl/stdp_weight_update_if.sv
// Spike inputs and weight/update outputs of the STDP synapse.
interface stdp_weight_update_if;
    import stdp_weight_update_pkg::*;

    logic                learn_en;
    logic                pre_spike;
    logic                post_spike;
    logic [WEIGHT_W-1:0] weight;
    logic [WEIGHT_W-1:0] syn_current;
    logic                update_w_flag;
    logic                ltp;
    logic [3:0]          time_diff;

    modport master (
        output learn_en, pre_spike, post_spike,
        input  weight, syn_current, update_w_flag, ltp, time_diff
    );

    modport slave (
        input  learn_en, pre_spike, post_spike,
        output weight, syn_current, update_w_flag, ltp, time_diff
    );

endinterface

// File: rtl/stdp_spike_timer.sv
// Saturating counter of cycles elapsed since the most recent spike.
module stdp_spike_timer
    import stdp_weight_update_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spike,
    output logic [CNT_W-1:0] cnt
);

    // Restart on a spike, otherwise count up and stick at the saturation value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= CNT_SAT;
        end else if (spike) begin
            cnt <= '0;
        end else if (cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stdp_weight_update.sv
// Pair-based STDP synapse: potentiates on post-after-pre, optionally depresses
// on pre-after-post, and drives the weighted presynaptic current.
// Optional feature macro: STDP_DEPRESS_EN (depression on pre spikes).
module stdp_weight_update
    import stdp_weight_update_pkg::*;
#(
    parameter int W_INIT = DEF_W_INIT,
    parameter int A_MAX  = DEF_A_MAX,
    parameter int WINDOW = DEF_WINDOW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stdp_weight_update_if.slave  bus
);

`ifdef STDP_DEPRESS_EN
    localparam bit DEPRESS_EN = 1'b1;
`else
    localparam bit DEPRESS_EN = 1'b0;
`endif

    localparam logic [WEIGHT_W-1:0] W_INIT_V = W_INIT[WEIGHT_W-1:0];
    localparam logic [WEIGHT_W-1:0] W_MAX_V  = '1;

    logic [CNT_W-1:0]    pre_cnt;
    logic [CNT_W-1:0]    post_cnt;
    logic [CNT_W-1:0]    pre_age;
    logic [CNT_W-1:0]    post_age;
    logic [CNT_W-1:0]    partner_age;
    upd_kind_t           upd_kind;
    logic [WEIGHT_W:0]   delta;
    logic [WEIGHT_W:0]   sum;
    logic [WEIGHT_W-1:0] weight_next;

    logic [WEIGHT_W-1:0] weight_q;
    logic [WEIGHT_W-1:0] syn_q;
    logic                flag_q;
    logic                ltp_q;
    logic [3:0]          td_q;

    stdp_spike_timer u_pre_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .spike (bus.pre_spike),
        .cnt   (pre_cnt)
    );

    stdp_spike_timer u_post_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .spike (bus.post_spike),
        .cnt   (post_cnt)
    );

    assign pre_age  = spike_age(pre_cnt);
    assign post_age = spike_age(post_cnt);

    // Decide which rule fires this edge and compute the saturated new weight;
    // coincident spikes cancel each other and never update.
    always_comb begin
        upd_kind    = UPD_NONE;
        partner_age = '0;
        if (bus.learn_en && bus.post_spike && !bus.pre_spike && in_window(pre_age, WINDOW)) begin
            upd_kind    = UPD_LTP;
            partner_age = pre_age;
        end else if (DEPRESS_EN && bus.learn_en && bus.pre_spike && !bus.post_spike &&
                     in_window(post_age, WINDOW)) begin
            upd_kind    = UPD_LTD;
            partner_age = post_age;
        end

        delta       = stdp_delta(A_MAX, partner_age);
        sum         = {1'b0, weight_q} + delta;
        weight_next = weight_q;
        case (upd_kind)
            UPD_LTP: weight_next = sum[WEIGHT_W] ? W_MAX_V : sum[WEIGHT_W-1:0];
            UPD_LTD: weight_next = (delta > {1'b0, weight_q}) ? '0
                                   : weight_q - delta[WEIGHT_W-1:0];
            default: weight_next = weight_q;
        endcase
    end

    // Register weight, drive current and update status on the spike-sampling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            weight_q <= W_INIT_V;
            syn_q    <= '0;
            flag_q   <= 1'b0;
            ltp_q    <= 1'b0;
            td_q     <= '0;
        end else begin
            syn_q  <= bus.pre_spike ? weight_q : '0;
            flag_q <= (upd_kind != UPD_NONE);
            if (upd_kind != UPD_NONE) begin
                weight_q <= weight_next;
                ltp_q    <= (upd_kind == UPD_LTP);
                td_q     <= partner_age[3:0];
            end
        end
    end

    assign bus.weight        = weight_q;
    assign bus.syn_current   = syn_q;
    assign bus.update_w_flag = flag_q;
    assign bus.ltp           = ltp_q;
    assign bus.time_diff     = td_q;

endmodule
